round_sat_pipe: RTL and testbench
=================================

Name: round_sat_pipe

Overview:
Pipelined, multi-channel successor to the combinational rounding/overflow stage. It requantises a wide signed accumulator word (ACC_FRAC fractional bits) to a narrow signed output word (OUT_FRAC fractional bits). The rounding mode is selectable per sample, saturation is flagged, and the block has a valid/ready handshake with backpressure. Per-channel saturating event counters support filter-chain monitoring. It sits between each filter MAC accumulator and the next stage.

Parameters:
ACC_WIDTH, 42, accumulator input width (signed)
ACC_FRAC, 32, accumulator fractional bits
OUT_WIDTH, 16, output width (signed)
OUT_FRAC, 15, output fractional bits; FRAC_DIFF = ACC_FRAC-OUT_FRAC, must be >= 2 (elaboration error otherwise)
NUM_CH, 4, number of channels tagged on the stream
CNT_WIDTH, 16, width of each event counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
data_in  in  ACC_WIDTH  signed accumulator sample
ch_in  in  $clog2(NUM_CH)  channel tag of data_in
mode_in  in  2  rounding mode (round_mode_e), sampled with data
valid_in  in  1  input sample valid
ready_in  out  1  block can accept a sample
data_out  out  OUT_WIDTH  rounded/saturated sample
ch_out  out  $clog2(NUM_CH)  channel tag carried through
overflow  out  1  sample saturated at MAX
underflow  out  1  sample saturated at MIN
valid_out  out  1  output valid
ready_out  in  1  downstream accepts
cnt_sel  in  $clog2(NUM_CH)  channel whose counters are read
ovf_cnt  out  CNT_WIDTH  overflow count of cnt_sel (combinational mux)
unf_cnt  out  CNT_WIDTH  underflow count of cnt_sel
cnt_clr  in  1  synchronous clear of all counters

Behaviour:
- Reset: all stage valids=0, data_out=0, ch_out=0, overflow=underflow=0, valid_out=0, all counters=0. Reset mid-stream drops in-flight samples; no partial output.
- Pipeline: 2 stages, latency exactly 2 cycles from acceptance (valid_in&&ready_in) to valid_out when ready_out stays high. Throughput 1 sample/cycle.
- Stall: en = ready_out || !valid_out; ready_in = en. When en=0, both stages hold their contents; data_out, flags and ch_out stay stable while valid_out=1 and ready_out=0.
- Stage 1 (round): raw = data_in >>> FRAC_DIFF (RAW_WIDTH = ACC_WIDTH-FRAC_DIFF). guard = bit FRAC_DIFF-1; rest = OR of bits FRAC_DIFF-2..0. The increment depends on mode:
  - TRUNC: inc=0 (floor).
  - HALF_UP: inc=guard.
  - HALF_EVEN: inc = guard && (rest || raw[0]).
  - Reserved code 2'b11 behaves as HALF_EVEN.
  - sum = raw + inc, computed at RAW_WIDTH+1 bits, so no wrap is possible.
- Stage 2 (saturate): if sum > 2^(OUT_WIDTH-1)-1, data_out=MAX and overflow=1. If sum < -2^(OUT_WIDTH-1), data_out=MIN and underflow=1. Otherwise data_out = sum[OUT_WIDTH-1:0]. The comparison is on the full-width sum, never on the truncated value. overflow and underflow are never both 1.
- mode_in and ch_in are captured at acceptance and travel with the sample. A mode change affects only newly accepted samples.
- Counters: on output handshake (valid_out&&ready_out), increment ovf_cnt[ch_out] if overflow, or unf_cnt[ch_out] if underflow. Each counter saturates at all-ones and does not wrap.
- cnt_clr has priority: on a cycle with cnt_clr=1, all counters become 0 and any coincident increment is lost.
- Counters do not change while stalled.

Decomposition:
- Package round_sat_pkg holds:
  - round_mode_e: RND_TRUNC=2'b00, RND_HALF_UP=2'b01, RND_HALF_EVEN=2'b10, RND_RSVD=2'b11.
  - Functions out_max(OUT_WIDTH) and out_min(OUT_WIDTH).
- One combinational sub-module round_incr (inputs data_in, mode; outputs raw, inc) computes stage-1 logic so it can be unit-tested alone. Saturation, pipeline and counters stay in the top.

Test Plan:
1. Default params, HALF_EVEN, data_in=2^31 (0.5) -> 2 cycles later data_out=16384, no flags.
2. Tie cases, data_in=2^18+2^16 (raw 2, exactly half) -> HALF_EVEN 2, HALF_UP 3, TRUNC 2. For data_in=-196608 (raw -2, half) -> HALF_EVEN -2, HALF_UP -1, TRUNC -2. For data_in=2^17+2^16 -> HALF_EVEN 2.
3. Saturation with ch_in=1:
   - data_in=2^32 (1.0) -> data_out=32767, overflow=1, ovf_cnt[1]=1.
   - data_in=-(2^32)-2^17 -> data_out=-32768, underflow=1, unf_cnt[1]=1.
   - data_in=2^32-2^16 rounds up to 32768 -> saturates to 32767 with overflow=1 (rounding-induced overflow).
4. Backpressure: stream 8 samples back-to-back, hold ready_out=0 for 3 cycles mid-stream -> ready_in=0 while stalled, outputs stable, all 8 emitted in order with no loss or duplicate.
5. Counters: drive 2^CNT_WIDTH+5 overflows on ch 0 -> ovf_cnt=all-ones. Assert cnt_clr on the same cycle as an overflow handshake -> counter=0 afterwards.
6. Reset: assert rst with 2 samples in flight -> next cycle valid_out=0, counters 0. Post-reset samples have 2-cycle latency.

Source files
------------

// File: rtl/round_sat_pkg.sv
// round_sat_pkg: shared types and helpers for the round/saturate pipeline.
//   round_mode_e : per-sample rounding mode carried with each sample
//   out_max/out_min : largest/smallest value of a signed word of a given width
package round_sat_pkg;

   typedef enum logic [1:0] {
      RND_TRUNC     = 2'b00,
      RND_HALF_UP   = 2'b01,
      RND_HALF_EVEN = 2'b10,
      RND_RSVD      = 2'b11
   } round_mode_e;

   function automatic longint out_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic longint out_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/round_sat_pipe_round_incr.sv
// round_incr: combinational rounding decision for one accumulator sample.
//   data_in : signed accumulator word
//   mode    : rounding mode
//   raw     : data_in arithmetically shifted right by FRAC_DIFF (floor)
//   inc     : 1 when the rounded result is raw + 1
module round_incr
   import round_sat_pkg::*;
#(
   parameter int ACC_WIDTH = 42,
   parameter int FRAC_DIFF = 17,
   localparam int RAW_WIDTH = ACC_WIDTH - FRAC_DIFF
) (
   input  logic signed [ACC_WIDTH-1:0] data_in,
   input  round_mode_e                 mode,
   output logic signed [RAW_WIDTH-1:0] raw,
   output logic                        inc
);

   logic guard_s;
   logic rest_s;

   // Split the word into kept part, guard bit and sticky rest; pick the increment.
   always_comb begin
      raw     = data_in[ACC_WIDTH-1:FRAC_DIFF];
      guard_s = data_in[FRAC_DIFF-1];
      rest_s  = |data_in[FRAC_DIFF-2:0];
      inc     = 1'b0;
      case (mode)
         RND_TRUNC:     inc = 1'b0;
         RND_HALF_UP:   inc = guard_s;
         // An exact tie (guard set, rest clear) rounds up only if raw is odd.
         RND_HALF_EVEN: inc = guard_s & (rest_s | data_in[FRAC_DIFF]);
         RND_RSVD:      inc = guard_s & (rest_s | data_in[FRAC_DIFF]);
         default:       inc = guard_s & (rest_s | data_in[FRAC_DIFF]);
      endcase
   end

endmodule

// File: rtl/round_sat_pipe.sv
// round_sat_pipe: two-stage requantiser from a wide accumulator word to a
// narrow signed output with selectable rounding, saturation flags,
// valid/ready backpressure and per-channel saturation event counters.
//   clk, rst            : clock, synchronous active-high reset
//   data_in/ch_in/mode_in/valid_in/ready_in : input stream
//   data_out/ch_out/overflow/underflow/valid_out/ready_out : output stream
//   cnt_sel/ovf_cnt/unf_cnt : counter readback (combinational mux)
//   cnt_clr             : synchronous clear of all counters
module round_sat_pipe
   import round_sat_pkg::*;
#(
   parameter int ACC_WIDTH = 42,
   parameter int ACC_FRAC  = 32,
   parameter int OUT_WIDTH = 16,
   parameter int OUT_FRAC  = 15,
   parameter int NUM_CH    = 4,
   parameter int CNT_WIDTH = 16,
   localparam int CH_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [ACC_WIDTH-1:0] data_in,
   input  logic        [CH_WIDTH-1:0]  ch_in,
   input  round_mode_e                 mode_in,
   input  logic                        valid_in,
   output logic                        ready_in,
   output logic signed [OUT_WIDTH-1:0] data_out,
   output logic        [CH_WIDTH-1:0]  ch_out,
   output logic                        overflow,
   output logic                        underflow,
   output logic                        valid_out,
   input  logic                        ready_out,
   input  logic        [CH_WIDTH-1:0]  cnt_sel,
   output logic        [CNT_WIDTH-1:0] ovf_cnt,
   output logic        [CNT_WIDTH-1:0] unf_cnt,
   input  logic                        cnt_clr
);

   localparam int FRAC_DIFF = ACC_FRAC - OUT_FRAC;
   localparam int RAW_WIDTH = ACC_WIDTH - FRAC_DIFF;
   localparam int SUM_WIDTH = RAW_WIDTH + 1;
   // Counter arrays cover every encodable tag so indexing never leaves the array.
   localparam int CNT_SLOTS = 1 << CH_WIDTH;

   localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = SUM_WIDTH'(out_max(OUT_WIDTH));
   localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = SUM_WIDTH'(out_min(OUT_WIDTH));
   localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = OUT_WIDTH'(out_max(OUT_WIDTH));
   localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = OUT_WIDTH'(out_min(OUT_WIDTH));
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = {CNT_WIDTH{1'b1}};

   generate
      if (FRAC_DIFF < 2) begin : g_bad_frac_diff
         $error("round_sat_pipe: ACC_FRAC - OUT_FRAC must be at least 2");
      end
      if (RAW_WIDTH < OUT_WIDTH) begin : g_bad_widths
         $error("round_sat_pipe: ACC_WIDTH - FRAC_DIFF must be at least OUT_WIDTH");
      end
   endgenerate

   logic                        en_s;
   logic                        accept_s;
   logic                        out_hs_s;
   logic signed [RAW_WIDTH-1:0] raw_s;
   logic                        inc_s;
   logic signed [SUM_WIDTH-1:0] sum_s;

   logic                        s1_valid_r;
   logic signed [SUM_WIDTH-1:0] s1_sum_r;
   logic        [CH_WIDTH-1:0]  s1_ch_r;

   logic signed [OUT_WIDTH-1:0] sat_data_s;
   logic                        sat_ovf_s;
   logic                        sat_unf_s;

   logic [CNT_WIDTH-1:0] ovf_cnt_r [CNT_SLOTS];
   logic [CNT_WIDTH-1:0] unf_cnt_r [CNT_SLOTS];

   round_incr #(
      .ACC_WIDTH (ACC_WIDTH),
      .FRAC_DIFF (FRAC_DIFF)
   ) u_round_incr (
      .data_in (data_in),
      .mode    (mode_in),
      .raw     (raw_s),
      .inc     (inc_s)
   );

   // Handshake: the whole pipe advances whenever the output slot is free or draining.
   always_comb begin
      en_s     = ready_out | ~valid_out;
      ready_in = en_s;
      accept_s = valid_in & en_s;
      out_hs_s = valid_out & ready_out;
   end

   // Rounded sum is one bit wider than raw so raw = max plus one cannot wrap.
   always_comb begin
      sum_s = {raw_s[RAW_WIDTH-1], raw_s} + {{RAW_WIDTH{1'b0}}, inc_s};
   end

   // Saturation decided on the full-width sum, never on the truncated word.
   always_comb begin
      sat_data_s = s1_sum_r[OUT_WIDTH-1:0];
      sat_ovf_s  = 1'b0;
      sat_unf_s  = 1'b0;
      if (s1_sum_r > SUM_MAX) begin
         sat_data_s = OUT_MAX;
         sat_ovf_s  = 1'b1;
      end else if (s1_sum_r < SUM_MIN) begin
         sat_data_s = OUT_MIN;
         sat_unf_s  = 1'b1;
      end else begin
         sat_data_s = s1_sum_r[OUT_WIDTH-1:0];
      end
   end

   // Stage 1: capture the rounded sum and tag of each accepted sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_sum_r   <= {SUM_WIDTH{1'b0}};
         s1_ch_r    <= {CH_WIDTH{1'b0}};
      end else if (en_s) begin
         s1_valid_r <= valid_in;
         if (accept_s) begin
            s1_sum_r <= sum_s;
            s1_ch_r  <= ch_in;
         end
      end
   end

   // Stage 2: registered saturated output; payload only reloads on a real sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out <= 1'b0;
         data_out  <= {OUT_WIDTH{1'b0}};
         ch_out    <= {CH_WIDTH{1'b0}};
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (en_s) begin
         valid_out <= s1_valid_r;
         if (s1_valid_r) begin
            data_out  <= sat_data_s;
            ch_out    <= s1_ch_r;
            overflow  <= sat_ovf_s;
            underflow <= sat_unf_s;
         end
      end
   end

   // Per-channel saturating event counters; a clear wins over a coincident increment.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         for (int i = 0; i < CNT_SLOTS; i++) begin
            ovf_cnt_r[i] <= CNT_ZERO;
            unf_cnt_r[i] <= CNT_ZERO;
         end
      end else if (out_hs_s) begin
         if (overflow && (ovf_cnt_r[ch_out] != CNT_FULL)) begin
            ovf_cnt_r[ch_out] <= ovf_cnt_r[ch_out] + CNT_ONE;
         end
         if (underflow && (unf_cnt_r[ch_out] != CNT_FULL)) begin
            unf_cnt_r[ch_out] <= unf_cnt_r[ch_out] + CNT_ONE;
         end
      end
   end

   // Counter readback mux.
   always_comb begin
      ovf_cnt = ovf_cnt_r[cnt_sel];
      unf_cnt = unf_cnt_r[cnt_sel];
   end

endmodule

// File: tb/tb_round_sat_pipe.sv
// tb_round_sat_pipe: directed self-checking bench for round_sat_pipe with
// hand-computed expected values (default parameters, FRAC_DIFF = 17).
module tb_round_sat_pipe;
   import round_sat_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [41:0] data_in;
   logic        [1:0]  ch_in;
   round_mode_e        mode_in;
   logic               valid_in;
   logic               ready_in;
   logic signed [15:0] data_out;
   logic        [1:0]  ch_out;
   logic               overflow;
   logic               underflow;
   logic               valid_out;
   logic               ready_out;
   logic        [1:0]  cnt_sel;
   logic        [15:0] ovf_cnt;
   logic        [15:0] unf_cnt;
   logic               cnt_clr;

   int n_cmp = 0;
   int n_mis = 0;

   round_sat_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .ch_in     (ch_in),
      .mode_in   (mode_in),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .data_out  (data_out),
      .ch_out    (ch_out),
      .overflow  (overflow),
      .underflow (underflow),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .cnt_sel   (cnt_sel),
      .ovf_cnt   (ovf_cnt),
      .unf_cnt   (unf_cnt),
      .cnt_clr   (cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated sample: checks 2-cycle latency, payload, flags and tag.
   task automatic run_vec(input string tag, input longint din, input round_mode_e mode,
                          input logic [1:0] ch, input longint exp_d,
                          input logic exp_o, input logic exp_u);
      data_in  = 42'(din);
      mode_in  = mode;
      ch_in    = ch;
      valid_in = 1'b1;
      check_val({tag, "_ready_in"}, ready_in, 1);
      step();
      valid_in = 1'b0;
      check_val({tag, "_early"}, valid_out, 0);
      step();
      check_val({tag, "_valid"}, valid_out, 1);
      check_val({tag, "_data"}, data_out, exp_d);
      check_val({tag, "_ovf"}, overflow, exp_o);
      check_val({tag, "_unf"}, underflow, exp_u);
      check_val({tag, "_ch"}, ch_out, ch);
      step();
   endtask

   initial begin
      logic signed [15:0] held;
      bit                 held_v;
      int                 tx;
      int                 rx;

      rst = 1'b1; data_in = 42'sd0; ch_in = 2'd0; mode_in = RND_TRUNC;
      valid_in = 1'b0; ready_out = 1'b1; cnt_sel = 2'd0; cnt_clr = 1'b0;
      step();
      step();
      check_val("rst_valid_out", valid_out, 0);
      check_val("rst_data_out", data_out, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_unf", underflow, 0);
      check_val("rst_ch_out", ch_out, 0);
      check_val("rst_ovf_cnt", ovf_cnt, 0);
      check_val("rst_unf_cnt", unf_cnt, 0);
      rst = 1'b0;
      step();

      // Rounding: 0.5, ties in each mode, reserved code, non-tie.
      run_vec("half", 64'sd2147483648, RND_HALF_EVEN, 2'd0, 16384, 1'b0, 1'b0);
      run_vec("tie2_he", 64'sd327680, RND_HALF_EVEN, 2'd0, 2, 1'b0, 1'b0);
      run_vec("tie2_hu", 64'sd327680, RND_HALF_UP, 2'd2, 3, 1'b0, 1'b0);
      run_vec("tie2_tr", 64'sd327680, RND_TRUNC, 2'd3, 2, 1'b0, 1'b0);
      run_vec("tien2_he", -64'sd196608, RND_HALF_EVEN, 2'd0, -2, 1'b0, 1'b0);
      run_vec("tien2_hu", -64'sd196608, RND_HALF_UP, 2'd0, -1, 1'b0, 1'b0);
      run_vec("tien2_tr", -64'sd196608, RND_TRUNC, 2'd0, -2, 1'b0, 1'b0);
      run_vec("tie1_he", 64'sd196608, RND_HALF_EVEN, 2'd0, 2, 1'b0, 1'b0);
      run_vec("tie1_rsvd", 64'sd196608, RND_RSVD, 2'd0, 2, 1'b0, 1'b0);
      run_vec("tie1_tr", 64'sd196608, RND_TRUNC, 2'd0, 1, 1'b0, 1'b0);
      run_vec("above_he", 64'sd327681, RND_HALF_EVEN, 2'd0, 3, 1'b0, 1'b0);

      // Saturation on channel 1 plus exact full-scale boundaries.
      cnt_sel = 2'd1;
      run_vec("sat_pos", 64'sd4294967296, RND_HALF_EVEN, 2'd1, 32767, 1'b1, 1'b0);
      check_val("sat_pos_cnt", ovf_cnt, 1);
      run_vec("sat_neg", -64'sd4295098368, RND_HALF_EVEN, 2'd1, -32768, 1'b0, 1'b1);
      check_val("sat_neg_cnt", unf_cnt, 1);
      run_vec("sat_rnd", 64'sd4294901760, RND_HALF_EVEN, 2'd1, 32767, 1'b1, 1'b0);
      check_val("sat_rnd_cnt", ovf_cnt, 2);
      run_vec("edge_max", 64'sd4294836224, RND_HALF_EVEN, 2'd1, 32767, 1'b0, 1'b0);
      run_vec("edge_min", -64'sd4294967296, RND_HALF_EVEN, 2'd1, -32768, 1'b0, 1'b0);
      check_val("edge_ovf_cnt", ovf_cnt, 2);
      check_val("edge_unf_cnt", unf_cnt, 1);
      cnt_sel = 2'd0;
      check_val("ch0_ovf_cnt", ovf_cnt, 0);

      // Backpressure: 8 back-to-back samples, ready_out low for 3 cycles.
      tx = 0; rx = 0; held = 16'sd0; held_v = 1'b0;
      for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
         ready_out = (cyc >= 4 && cyc <= 6) ? 1'b0 : 1'b1;
         #1;
         if (valid_out && !ready_out) begin
            check_val("bp_ready_in", ready_in, 0);
            if (held_v) check_val("bp_hold", data_out, held);
            held   = data_out;
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (valid_out && ready_out) begin
            check_val("bp_data", data_out, rx + 10);
            rx++;
         end
         if (tx < 8) begin
            valid_in = 1'b1;
            data_in  = 42'(longint'(tx + 10) <<< 17);
            mode_in  = RND_TRUNC;
            ch_in    = 2'd2;
         end else begin
            valid_in = 1'b0;
         end
         if (valid_in && ready_in) tx++;
         step();
      end
      valid_in  = 1'b0;
      ready_out = 1'b1;
      check_val("bp_rx_count", rx, 8);
      check_val("bp_tx_count", tx, 8);
      step();
      step();
      check_val("bp_no_dup", valid_out, 0);

      // Counter saturation: 2^16 + 5 overflows on channel 0.
      cnt_clr = 1'b1;
      step();
      cnt_clr  = 1'b0;
      cnt_sel  = 2'd0;
      data_in  = 42'sd4294967296;
      ch_in    = 2'd0;
      mode_in  = RND_HALF_EVEN;
      valid_in = 1'b1;
      repeat (65541) step();
      valid_in = 1'b0;
      repeat (3) step();
      check_val("cnt_sat_ovf", ovf_cnt, 16'hFFFF);
      check_val("cnt_sat_unf", unf_cnt, 0);

      // Clear coincident with an overflow handshake (counter saturated).
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      check_val("clr1_ovf_flag", overflow, 1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check_val("clr1_cnt", ovf_cnt, 0);
      check_val("clr1_consumed", valid_out, 0);

      // Counters hold while the output is stalled.
      valid_in = 1'b1;
      step();
      valid_in  = 1'b0;
      ready_out = 1'b0;
      step();
      step();
      step();
      check_val("stall_valid", valid_out, 1);
      check_val("stall_cnt", ovf_cnt, 0);
      ready_out = 1'b1;
      step();
      check_val("stall_release_cnt", ovf_cnt, 1);

      // Clear coincident with an increment from a non-zero count.
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check_val("clr2_cnt", ovf_cnt, 0);
      run_vec("pre_rst", 64'sd4294967296, RND_HALF_EVEN, 2'd0, 32767, 1'b1, 1'b0);
      check_val("pre_rst_cnt", ovf_cnt, 1);

      // Reset with two samples in flight.
      data_in = 42'sd4294967296; ch_in = 2'd2; valid_in = 1'b1;
      step();
      data_in = 42'sd2147483648; ch_in = 2'd3;
      step();
      valid_in = 1'b0;
      check_val("inflight_valid", valid_out, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("mid_rst_valid", valid_out, 0);
      check_val("mid_rst_data", data_out, 0);
      check_val("mid_rst_ovf", overflow, 0);
      check_val("mid_rst_ch", ch_out, 0);
      check_val("mid_rst_cnt0", ovf_cnt, 0);
      cnt_sel = 2'd2;
      check_val("mid_rst_cnt2", ovf_cnt, 0);
      step();
      check_val("mid_rst_drop1", valid_out, 0);
      step();
      check_val("mid_rst_drop2", valid_out, 0);
      run_vec("post_rst", 64'sd327680, RND_HALF_UP, 2'd1, 3, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
